// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : Stall/flush sequencer for a five-stage pipeline with a
//            multi-cycle data-memory wait state and sticky timeout halt.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_sequencer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_freeze,
    input  logic        branch_taken,
    input  logic        mem_busy,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_exe_en,
    output logic        exe_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_exe_flush,
    output logic [1:0]  state,
    output logic        mem_timeout,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [1:0]  c_RUN       = 2'd0;
    localparam logic [1:0]  c_MEM_WAIT  = 2'd1;
    localparam logic [1:0]  c_HALT      = 2'd2;
    localparam logic [7:0]  c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [15:0] c_SAT       = 16'hFFFF;

    logic [1:0]  r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_pending_flush;
    logic        r_mem_timeout;
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    logic        w_stall_all;
    logic        w_branch;

    // A completing memory wait replays the RUN rules, with any branch seen
    // during the wait folded into the branch request.
    always_comb begin
        w_stall_all = 1'b1;
        w_branch    = 1'b0;
        case (r_state)
            c_RUN: begin
                w_stall_all = mem_busy;
                w_branch    = branch_taken;
            end
            c_MEM_WAIT: begin
                w_stall_all = ~mem_ready;
                w_branch    = branch_taken | r_pending_flush;
            end
            default: begin
                w_stall_all = 1'b1;
                w_branch    = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_exe_en    = 1'b0;
        exe_mem_en   = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        if (!w_stall_all) begin
            id_exe_en  = 1'b1;
            exe_mem_en = 1'b1;
            mem_wb_en  = 1'b1;
            if (w_branch) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
            end else if (hazard_freeze) begin
                id_exe_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= c_RUN;
            r_wait_cnt      <= 8'd0;
            r_pending_flush <= 1'b0;
            r_mem_timeout   <= 1'b0;
            r_stall_count   <= 16'd0;
            r_flush_count   <= 16'd0;
        end else begin
            if (r_state != c_HALT && !pc_en && r_stall_count != c_SAT)
                r_stall_count <= r_stall_count + 16'd1;
            if (if_id_flush && r_flush_count != c_SAT)
                r_flush_count <= r_flush_count + 16'd1;

            case (r_state)
                c_RUN: begin
                    if (mem_busy) begin
                        r_state         <= c_MEM_WAIT;
                        r_wait_cnt      <= 8'd0;
                        r_pending_flush <= branch_taken;
                    end
                end
                c_MEM_WAIT: begin
                    // mem_busy is deliberately ignored here: no nested waits.
                    if (mem_ready) begin
                        r_state         <= c_RUN;
                        r_pending_flush <= 1'b0;
                    end else begin
                        r_wait_cnt      <= r_wait_cnt + 8'd1;
                        r_pending_flush <= r_pending_flush | branch_taken;
                        if (r_wait_cnt == c_WAIT_LAST) begin
                            r_mem_timeout <= 1'b1;
                            r_state       <= c_HALT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign state       = r_state;
    assign mem_timeout = r_mem_timeout;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_sequencer
// Purpose  : Scoreboard bench for pipeline_sequencer against a rule-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_sequencer;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hazard_freeze = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0, mem_ready = 1'b0;
    logic        pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_flush, id_exe_flush;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [15:0] stall_count, flush_count;

    pipeline_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .hazard_freeze(hazard_freeze), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
        .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
        .state(state), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  ctl;   // pc, if_id, id_exe, exe_mem, mem_wb, if_id_flush, id_exe_flush
        logic [1:0]  st;
        logic        to;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0=running, 1=waiting on memory, 2=halted.
    int   m_mode, m_waited, m_stalls, m_flushes;
    bit   m_pend, m_to;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_stalls = 0; m_flushes = 0; m_pend = 0; m_to = 0;
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic cycle(input bit hz, input bit br, input bit busy, input bit rdy, input bit rstv);
        bit   frozen, brq;
        logic [6:0] ctl;
        exp_t e;
        @(negedge clk);
        hazard_freeze = hz; branch_taken = br; mem_busy = busy; mem_ready = rdy; rst = rstv;
        if (!rstv) model_reset();

        frozen = (m_mode == 2) || (m_mode == 0 && busy) || (m_mode == 1 && !rdy);
        brq    = br || (m_mode == 1 && m_pend);
        if (frozen)   ctl = 7'b0000000;
        else if (brq) ctl = 7'b1111111;
        else if (hz)  ctl = 7'b0011101;
        else          ctl = 7'b1111100;
        e.ctl = ctl; e.st = 2'(m_mode); e.to = m_to;
        e.sc = 16'(m_stalls); e.fc = 16'(m_flushes);
        q.push_back(e);

        if (rstv) begin
            if (m_mode != 2 && !ctl[6]) m_stalls  = (m_stalls  < 65535) ? m_stalls + 1  : 65535;
            if (ctl[1])                 m_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
            if (m_mode == 0 && busy) begin
                m_mode = 1; m_waited = 0; m_pend = br;
            end else if (m_mode == 1) begin
                if (rdy) begin
                    m_mode = 0; m_pend = 0;
                end else begin
                    m_waited++;
                    m_pend = m_pend | br;
                    if (m_waited == TMO) begin m_mode = 2; m_to = 1; end
                end
            end
        end
    endtask

    // Direct register checks against hand-derived values, just after an edge.
    task automatic peek(input string tag, input int st, input int to, input int sc, input int fc);
        @(posedge clk); #1;
        check({tag, "_state"}, state, st);
        check({tag, "_timeout"}, mem_timeout, to);
        check({tag, "_stall_count"}, stall_count, sc);
        check({tag, "_flush_count"}, flush_count, fc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sb_ctl", {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                                 if_id_flush, id_exe_flush}, e.ctl);
                check("sb_state", state, e.st);
                check("sb_timeout", mem_timeout, e.to);
                check("sb_stall_count", stall_count, e.sc);
                check("sb_flush_count", flush_count, e.fc);
            end
        end
    end

    initial begin : driver
        model_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        // Idle run
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1);
        peek("idle", 0, 0, 0, 0);
        // Two-cycle hazard freeze
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        peek("freeze", 0, 0, 2, 0);
        // Branch beats hazard
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 1);
        peek("branch", 0, 0, 0, 1);
        // Memory wait with a pending branch, ready after three wait cycles
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        peek("memwait", 0, 0, 4, 1);
        // Memory timeout into halt, then reset recovery
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 1);
        for (int i = 0; i < TMO; i++) cycle(0, 0, 0, 0, 1);
        peek("timeout", 2, 1, 5, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 1, 1);
        peek("halted", 2, 1, 5, 0);
        cycle(0, 0, 0, 0, 0);
        peek("halt_rst", 0, 0, 0, 0);
        // Reset in the middle of a wait carrying a pending flush
        cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 1, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1);
        peek("abort", 0, 0, 0, 0);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
                  ($urandom % 3) == 0, ($urandom % 50) != 0);
        repeat (3) @(negedge clk);
        check("sb_drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, range 2..255: maximum MEM_WAIT cycles before HALT.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 hazard_freeze  input  1  load-use or RAW freeze request from hazard detection in ID.
REQ-005 branch_taken  input  1  taken-branch indication from EXE.
REQ-006 mem_busy  input  1  data-memory multi-cycle access start request from MEM.
REQ-007 mem_ready  input  1  data-memory access complete.
REQ-008 pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en  output  1 each  PC and pipeline-register load enables.
REQ-009 if_id_flush, id_exe_flush  output  1 each  synchronous clear of IF/ID and ID/EXE registers; ID/EXE clear injects a bubble, all commands zero.
REQ-010 state  output  2  current FSM state: RUN=0, MEM_WAIT=1, HALT=2.
REQ-011 mem_timeout  output  1  sticky error flag.
REQ-012 stall_count, flush_count  output  16 each  saturating performance counters.

Function
REQ-013 Registered state: FSM, 8-bit wait_cnt, pending_flush, mem_timeout, both counters. Enables and flushes SHALL be combinational from current state and inputs, same cycle.
REQ-014 RUN priority SHALL be mem_busy > branch_taken > hazard_freeze.
REQ-015 RUN, mem_busy=1: all enables 0, flushes 0; next MEM_WAIT; wait_cnt<=0; pending_flush<=branch_taken.
REQ-016 RUN, mem_busy=0, branch_taken=1: all enables 1, if_id_flush=1, id_exe_flush=1; hazard_freeze ignored.
REQ-017 RUN, only hazard_freeze=1: pc_en=0, if_id_en=0, id_exe_flush=1, id_exe_en=exe_mem_en=mem_wb_en=1.
REQ-018 RUN, no requests: all enables 1, flushes 0.
REQ-019 MEM_WAIT, mem_ready=0: all enables 0, flushes 0; wait_cnt+1; pending_flush<=pending_flush|branch_taken.
REQ-020 MEM_WAIT, mem_ready=1: outputs per REQ-016..018 evaluated with mem_busy treated as 0 and branch_taken replaced by branch_taken|pending_flush; pending_flush<=0; next RUN.
REQ-021 MEM_WAIT, mem_ready=0 and wait_cnt==MEM_TIMEOUT-1: mem_timeout<=1; next HALT. mem_ready=1 in that cycle SHALL win (REQ-020, no timeout).
REQ-022 HALT: all enables 0, flushes 0; remains until reset; all inputs ignored.
REQ-023 mem_busy while in MEM_WAIT SHALL be ignored (no nesting, no wait_cnt restart).
REQ-024 stall_count SHALL increment each RUN or MEM_WAIT cycle with pc_en=0; never in HALT; saturates at 0xFFFF.
REQ-025 flush_count SHALL increment each cycle with if_id_flush=1; saturates at 0xFFFF.
REQ-026 mem_timeout SHALL clear only on reset.

Reset
REQ-027 rst=0 SHALL immediately force: state=RUN, wait_cnt=0, pending_flush=0, mem_timeout=0, stall_count=0, flush_count=0; combinational outputs follow RUN with current inputs.
REQ-028 Reset asserted in MEM_WAIT or HALT SHALL abort the wait; no pending flush survives.
REQ-029 First clock edge after rst deassertion SHALL evaluate RUN rules normally.

Verification
REQ-030 Idle: no requests 10 cycles -> all enables 1, flushes 0, stall_count=0, flush_count=0, state=0.
REQ-031 hazard_freeze=1 for 2 cycles -> pc_en=if_id_en=0, id_exe_flush=1 both cycles; stall_count=2.
REQ-032 branch_taken=1 with hazard_freeze=1 same cycle -> enables 1, both flushes 1, pc_en=1; flush_count=1, stall_count=0.
REQ-033 mem_busy=1 with branch_taken=1, mem_ready after 3 wait cycles -> all enables 0 for 4 cycles, ready cycle has enables 1 and both flushes 1; state returns 0; stall_count=4, flush_count=1.
REQ-034 MEM_TIMEOUT=4, mem_busy then mem_ready held 0 -> 4 MEM_WAIT cycles, then state=2, mem_timeout=1, enables 0; stall_count frozen at 5; rst pulse -> state=0, mem_timeout=0, counters 0.
REQ-035 rst asserted mid MEM_WAIT with pending_flush=1 -> after release, first cycle no flush, state=0.
